// File: rtl/uart_rx_deframer.sv
// UART receive deframer: synchronises Rx, mid-bit samples start/data/parity/stop
// and delivers the word with break/parity/frame status and FIFO overrun detection.
module uart_rx_deframer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_BIT   = 1,
  parameter int STOP_BITS    = 2
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Rx,
  input  logic                 FIFO_Full,
  output logic [DATA_BITS-1:0] Data_Out,
  output logic                 Data_Valid,
  output logic [2:0]           Rx_Error,
  output logic                 Overrun,
  output logic                 Rx_Busy,
  output logic                 RTS
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BMAX  = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
  localparam int BIT_W = $clog2(BMAX + 1);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] START      = 3'd1;
  localparam logic [2:0] DATA       = 3'd2;
  localparam logic [2:0] PARITY     = 3'd3;
  localparam logic [2:0] STOP       = 3'd4;
  localparam logic [2:0] DONE       = 3'd5;
  localparam logic [2:0] BREAK_WAIT = 3'd6;

  logic                 sync1_q, sync2_q, rx_prev_q;
  logic [1:0]           flush_q;
  logic                 armed_q, armed_d;
  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d, frm_q, frm_d, zero_q, zero_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [2:0]           err_q, err_d;
  logic                 valid_q, valid_d, ovr_q, ovr_d, busy_q, busy_d, rts_q;
  logic                 rx_s, sample;

  assign rx_s = sync2_q;

  // The start bit is sampled half a bit in; later bits a full bit apart.
  assign sample = (state_q == START) ? (cnt_q == CNT_W'(CLKS_PER_BIT/2 - 1))
                                     : (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  // A line low at reset release must first be seen high (after the synchroniser
  // has flushed its reset value) before a falling edge counts as a start.
  assign armed_d = armed_q | (flush_q[1] & rx_s);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    frm_d   = frm_q;
    zero_d  = zero_q;
    data_d  = data_q;
    err_d   = err_q;
    valid_d = 1'b0;
    ovr_d   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (armed_q && rx_prev_q && !rx_s) begin
          state_d = START;
          bit_d   = '0;
          par_d   = 1'b0;
          frm_d   = 1'b0;
          zero_d  = 1'b1;
        end
      end
      START: begin
        if (sample) begin
          cnt_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (sample) begin
          cnt_d   = '0;
          shift_d = {shift_q[DATA_BITS-2:0], rx_s};
          if (rx_s) zero_d = 1'b0;
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY_BIT != 0) ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (sample) begin
          cnt_d   = '0;
          par_d   = rx_s ^ (^shift_q);
          if (rx_s) zero_d = 1'b0;
          state_d = STOP;
        end
      end
      STOP: begin
        if (sample) begin
          cnt_d = '0;
          if (rx_s) zero_d = 1'b0;
          else      frm_d  = 1'b1;
          if (bit_q == BIT_W'(STOP_BITS - 1)) begin
            bit_d   = '0;
            state_d = DONE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      DONE: begin
        cnt_d = '0;
        if (zero_q) begin
          err_d   = 3'b001;
          state_d = BREAK_WAIT;
        end else begin
          err_d   = {frm_q, par_q, 1'b0};
          state_d = IDLE;
          if (FIFO_Full) begin
            ovr_d = 1'b1;
          end else begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end
        end
      end
      BREAK_WAIT: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rx_prev_q <= 1'b0;
      flush_q   <= '0;
      armed_q   <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      frm_q     <= 1'b0;
      zero_q    <= 1'b0;
      data_q    <= '0;
      err_q     <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
      busy_q    <= 1'b0;
      rts_q     <= 1'b0;
    end else begin
      sync1_q   <= Rx;
      sync2_q   <= sync1_q;
      rx_prev_q <= sync2_q;
      flush_q   <= {flush_q[0], 1'b1};
      armed_q   <= armed_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      frm_q     <= frm_d;
      zero_q    <= zero_d;
      data_q    <= data_d;
      err_q     <= err_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
      busy_q    <= busy_d;
      rts_q     <= ~FIFO_Full;
    end
  end

  assign Data_Out   = data_q;
  assign Data_Valid = valid_q;
  assign Rx_Error   = err_q;
  assign Overrun    = ovr_q;
  assign Rx_Busy    = busy_q;
  assign RTS        = rts_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer: table of single frames plus hand-written
// sequences for back-to-back, break, glitch, RTS latency and mid-frame reset.
module tb_uart_rx_deframer;

  localparam int CPB = 16;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       Rx = 1'b1;
  logic       FIFO_Full = 1'b0;
  logic [7:0] Data_Out;
  logic       Data_Valid;
  logic [2:0] Rx_Error;
  logic       Overrun;
  logic       Rx_Busy;
  logic       RTS;

  uart_rx_deframer #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (8),
    .PARITY_BIT  (1),
    .STOP_BITS   (2)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Rx        (Rx),
    .FIFO_Full (FIFO_Full),
    .Data_Out  (Data_Out),
    .Data_Valid(Data_Valid),
    .Rx_Error  (Rx_Error),
    .Overrun   (Overrun),
    .Rx_Busy   (Rx_Busy),
    .RTS       (RTS)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int valid_cnt = 0;
  int ovr_cnt   = 0;
  int t_last    = 0;
  int t_prev    = 0;
  logic busy_seen = 1'b0;

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (Data_Valid) begin
      valid_cnt = valid_cnt + 1;
      t_prev    = t_last;
      t_last    = cyc;
    end
    if (Overrun) ovr_cnt = ovr_cnt + 1;
    if (Rx_Busy) busy_seen = 1'b1;
  end

  typedef struct {
    logic [7:0] data;
    logic       par_bad;
    logic [1:0] stop;
    logic       ff;
    int         exp_nvalid;
    logic [7:0] exp_data;
    logic [2:0] exp_err;
    int         exp_novr;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    Rx = b;
    cycles(CPB);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_bad, input logic [1:0] stop);
    send_bit(1'b0);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    send_bit((^d) ^ par_bad);
    send_bit(stop[1]);
    send_bit(stop[0]);
    Rx = 1'b1;
  endtask

  int v0, o0;

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 2'b11, 1'b0, 1, 8'hA5, 3'b000, 0};
    vecs[1] = '{8'hAA, 1'b1, 2'b11, 1'b0, 1, 8'hAA, 3'b010, 0};
    vecs[2] = '{8'hAA, 1'b0, 2'b00, 1'b0, 1, 8'hAA, 3'b100, 0};
    vecs[3] = '{8'h11, 1'b0, 2'b11, 1'b1, 0, 8'hAA, 3'b000, 1};
    vecs[4] = '{8'hC3, 1'b1, 2'b01, 1'b0, 1, 8'hC3, 3'b110, 0};
    vecs[5] = '{8'h5A, 1'b0, 2'b10, 1'b0, 1, 8'h5A, 3'b100, 0};

    // reset state
    Rst = 1'b0;
    cycles(3);
    @(negedge Clk);
    check("rst_data",  32'(Data_Out), 32'h0);
    check("rst_err",   32'(Rx_Error), 32'h0);
    check("rst_busy",  32'(Rx_Busy),  32'h0);
    check("rst_rts",   32'(RTS),      32'h0);
    check("rst_valid", 32'(Data_Valid), 32'h0);
    @(posedge Clk); #1;
    Rst = 1'b1;
    cycles(10);
    @(negedge Clk);
    check("rts_after_rst", 32'(RTS), 32'h1);
    @(posedge Clk); #1;

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].ff) begin
        FIFO_Full = 1'b1;
        cycles(2);
      end
      v0 = valid_cnt;
      o0 = ovr_cnt;
      send_frame(vecs[i].data, vecs[i].par_bad, vecs[i].stop);
      cycles(20);
      check($sformatf("vec%0d_nvalid", i), 32'(valid_cnt - v0), 32'(vecs[i].exp_nvalid));
      check($sformatf("vec%0d_data", i),   32'(Data_Out),       32'(vecs[i].exp_data));
      check($sformatf("vec%0d_err", i),    32'(Rx_Error),       32'(vecs[i].exp_err));
      check($sformatf("vec%0d_novr", i),   32'(ovr_cnt - o0),   32'(vecs[i].exp_novr));
      FIFO_Full = 1'b0;
      cycles(2);
    end

    // back-to-back frames, no idle gap
    v0 = valid_cnt;
    send_frame(8'hA5, 1'b0, 2'b11);
    send_frame(8'h3C, 1'b0, 2'b11);
    cycles(20);
    check("b2b_nvalid", 32'(valid_cnt - v0), 32'd2);
    check("b2b_spacing", 32'(t_last - t_prev), 32'd192);
    check("b2b_data", 32'(Data_Out), 32'h3C);
    check("b2b_err",  32'(Rx_Error), 32'h0);

    // break: line low for 12 bit times plus 40 cycles
    v0 = valid_cnt;
    Rx = 1'b0;
    cycles(12 * CPB + 40);
    @(negedge Clk);
    check("brk_nvalid", 32'(valid_cnt - v0), 32'd0);
    check("brk_err",    32'(Rx_Error), 32'b001);
    check("brk_data",   32'(Data_Out), 32'h3C);
    check("brk_busy_low", 32'(Rx_Busy), 32'h1);
    @(posedge Clk); #1;
    Rx = 1'b1;
    cycles(2);
    @(negedge Clk);
    check("brk_busy_hold", 32'(Rx_Busy), 32'h1);
    @(posedge Clk); #1;
    @(negedge Clk);
    check("brk_busy_drop", 32'(Rx_Busy), 32'h0);
    @(posedge Clk); #1;
    cycles(10);

    // short glitch: 4 cycles low
    v0 = valid_cnt;
    busy_seen = 1'b0;
    Rx = 1'b0;
    cycles(4);
    Rx = 1'b1;
    cycles(30);
    check("glitch_busy_seen", 32'(busy_seen), 32'h1);
    check("glitch_busy_end",  32'(Rx_Busy),   32'h0);
    check("glitch_nvalid",    32'(valid_cnt - v0), 32'd0);
    check("glitch_err_hold",  32'(Rx_Error), 32'b001);

    // RTS follows FIFO_Full with one cycle of latency
    FIFO_Full = 1'b1;
    @(negedge Clk);
    check("rts_pre", 32'(RTS), 32'h1);
    @(posedge Clk); #1;
    @(negedge Clk);
    check("rts_post", 32'(RTS), 32'h0);
    @(posedge Clk); #1;
    FIFO_Full = 1'b0;
    cycles(3);
    check("rts_back", 32'(RTS), 32'h1);

    // reset in the middle of the data bits
    v0 = valid_cnt;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    Rst = 1'b0;
    Rx  = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    check("mid_rst_data", 32'(Data_Out), 32'h0);
    check("mid_rst_err",  32'(Rx_Error), 32'h0);
    check("mid_rst_busy", 32'(Rx_Busy),  32'h0);
    check("mid_rst_rts",  32'(RTS),      32'h0);
    @(posedge Clk); #1;
    Rst = 1'b1;
    cycles(10);
    send_frame(8'h5A, 1'b0, 2'b11);
    cycles(20);
    check("post_rst_nvalid", 32'(valid_cnt - v0), 32'd1);
    check("post_rst_data",   32'(Data_Out), 32'h5A);
    check("post_rst_err",    32'(Rx_Error), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
